mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, memory data width in bits.
REQ-002 Parameter DEPTH, default 128, memory word count; ADDR_W = $clog2(DEPTH) = 7.
REQ-003 Parameter CLEAR_ON_RESET, default 1, zero-fill memory after reset when 1.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) access request.
REQ-007 reqN_we  in  1  1=write, 0=read.
REQ-008 reqN_addr  in  ADDR_W  word address.
REQ-009 reqN_wdata  in  WIDTH  write data.
REQ-010 reqN_ready  out  1  grant; transfer occurs when valid and ready are both 1.
REQ-011 rspN_valid  out  1  read data valid pulse.
REQ-012 rspN_rdata  out  WIDTH  read data.
REQ-013 mem_rd_addr  out  ADDR_W  to memory_block rd_addr0.
REQ-014 mem_rd_dout  in  WIDTH  from memory_block rd_dout0 (combinational read).
REQ-015 mem_wr_addr  out  ADDR_W; mem_wr_din  out  WIDTH; mem_we  out  1  to memory_block write port (write on clk edge).
REQ-016 busy  out  1  high while clearing.

Function
REQ-017 FSM states CLEAR and SERVE; the block SHALL leave reset in CLEAR when CLEAR_ON_RESET=1, else in SERVE.
REQ-018 CLEAR: clr_cnt from 0 to DEPTH-1, one word per cycle, mem_we=1, mem_wr_addr=clr_cnt, mem_wr_din=0, both reqN_ready=0, busy=1.
REQ-019 CLEAR -> SERVE in the cycle after clr_cnt=DEPTH-1 is written (DEPTH cycles total); the counter SHALL NOT wrap.
REQ-020 SERVE: at most one access granted per cycle; busy=0.
REQ-021 Single valid requester: granted in the same cycle (reqN_ready combinational from valid and state).
REQ-022 Both valid: grant goes to the requester not granted last; last_grant resets to 1, so req0 wins the first tie.
REQ-023 last_grant SHALL update only on a completed transfer.
REQ-024 Granted write: mem_we=1, mem_wr_addr=addr, mem_wr_din=wdata in the same cycle; no response.
REQ-025 Granted read: mem_rd_addr=addr in the same cycle; rspN_valid=1 and rspN_rdata=mem_rd_dout registered on the next edge (latency 1), valid for one cycle.
REQ-026 Without a granted write, mem_we=0 and mem_wr_addr/mem_wr_din SHALL be 0; without a granted read, mem_rd_addr SHALL be 0.
REQ-027 rspN_rdata SHALL hold its last value when rspN_valid=0.
REQ-028 Back-to-back reads from one requester SHALL sustain one per cycle when the other is idle.
REQ-029 Read and write by the same requester are never simultaneous, so no read-during-write hazard exists.

Reset
REQ-030 On rst: reqN_ready=0, rspN_valid=0, rspN_rdata=0, mem_we=0, clr_cnt=0, last_grant=1, busy=CLEAR_ON_RESET.
REQ-031 rst asserted mid-CLEAR SHALL restart clearing at address 0.
REQ-032 rst asserted with a read in flight SHALL drop its response.

Structure
REQ-033 Package mem_ctrl_pkg SHALL hold WIDTH, DEPTH, ADDR_W and the FSM state enum (CLEAR, SERVE).
REQ-034 Sub-module rr_arb2 (two-way round-robin grant with last_grant register) SHALL be instantiated once.
REQ-035 memory_block is instantiated beside mem_arbiter at the top level, not inside it.

Verification
REQ-036 Reset, CLEAR_ON_RESET=1 -> busy high for 128 cycles, mem_we on addresses 0..127 with data 0, then busy=0.
REQ-037 req1 writes 0xDEADBEEF to addr 5, then req0 reads addr 5 -> rsp0_valid one cycle after grant, rsp0_rdata=0xDEADBEEF.
REQ-038 Both valid for 4 cycles (reads of addrs 1 and 2) -> grants alternate 0,1,0,1; each response is on its own port.
REQ-039 req0 only, reads of addrs 0..3 on consecutive cycles -> four responses on consecutive cycles, in order.
REQ-040 rst pulsed at clear count 60 -> clearing restarts at 0 and busy stays high for a further 128 cycles.
REQ-041 Read granted, rst in the next cycle -> rsp0_valid stays 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================
// mem_ctrl_pkg: shared sizes and FSM encoding for mem_arbiter
// Rev 1.0
// ============================================================
package mem_ctrl_pkg;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================
// rr_arb2: two-way round-robin grant, last winner remembered
// Rev 1.0
// ============================================================
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  // 1 means requester 1 won the most recent transfer
  logic r_last;

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_en) begin
      if (i_req0 && i_req1) begin
        o_gnt0 = r_last;
        o_gnt1 = !r_last;
      end else begin
        o_gnt0 = i_req0;
        o_gnt1 = i_req1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (o_gnt0 || o_gnt1) begin
      r_last <= o_gnt1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================
// mem_arbiter: two requesters onto one memory_block, with zero-fill
// Rev 1.0
// ============================================================
module mem_arbiter #(
  parameter  int WIDTH          = mem_ctrl_pkg::WIDTH,
  parameter  int DEPTH          = mem_ctrl_pkg::DEPTH,
  parameter  bit CLEAR_ON_RESET = 1'b1,
  localparam int ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [WIDTH-1:0]  rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [WIDTH-1:0]  rsp1_rdata,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_dout,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_din,
  output logic              mem_we,
  output logic              busy
);

  import mem_ctrl_pkg::*;

  localparam state_t            c_RESET_STATE = CLEAR_ON_RESET ? CLEAR : SERVE;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR   = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_serve;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_gnt_any;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WIDTH-1:0]  w_sel_wdata;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [WIDTH-1:0]  r_rsp0_rdata;
  logic [WIDTH-1:0]  r_rsp1_rdata;

  // Grants are masked while rst is high so an in-flight read cannot be captured
  assign w_serve = (r_state == SERVE) && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_serve),
    .i_req0 (req0_valid),
    .i_req1 (req1_valid),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign w_gnt_any   = w_gnt0 || w_gnt1;
  assign w_sel_we    = w_gnt1 ? req1_we    : req0_we;
  assign w_sel_addr  = w_gnt1 ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_gnt1 ? req1_wdata : req0_wdata;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter saturates at the last address so it never wraps back into a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if ((r_state == CLEAR) && (r_clr_cnt != c_LAST_ADDR)) begin
      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_we      = 1'b0;
    mem_wr_addr = '0;
    mem_wr_din  = '0;
    mem_rd_addr = '0;
    busy        = 1'b0;
    case (r_state)
      CLEAR: begin
        busy        = 1'b1;
        mem_we      = !rst;
        mem_wr_addr = r_clr_cnt;
        if (r_clr_cnt == c_LAST_ADDR) begin
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (w_gnt_any) begin
          if (w_sel_we) begin
            mem_we      = 1'b1;
            mem_wr_addr = w_sel_addr;
            mem_wr_din  = w_sel_wdata;
          end else begin
            mem_rd_addr = w_sel_addr;
          end
        end
      end
      default: w_state_nxt = c_RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_rsp0_valid <= w_gnt0 && !req0_we;
      r_rsp1_valid <= w_gnt1 && !req1_we;
      if (w_gnt0 && !req0_we) begin
        r_rsp0_rdata <= mem_rd_dout;
      end
      if (w_gnt1 && !req1_we) begin
        r_rsp1_rdata <= mem_rd_dout;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================
// tb_mem_arbiter: random + directed bench against a transaction-level model
// Rev 1.0
// ============================================================
module tb_mem_arbiter;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid, req0_we, req1_valid, req1_we;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [WIDTH-1:0]  req0_wdata, req1_wdata;
  logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0]  rsp0_rdata, rsp1_rdata;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [WIDTH-1:0]  mem_rd_dout, mem_wr_din;
  logic              mem_we, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
    .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din),
    .mem_we(mem_we), .busy(busy)
  );

  // Stand-in memory_block: combinational read, clocked write, pre-filled with garbage
  logic [WIDTH-1:0]  tb_mem [DEPTH];
  logic              fill_en = 1'b0;
  logic [ADDR_W-1:0] fill_addr = '0;
  logic [WIDTH-1:0]  fill_data = '0;

  always @(posedge clk) begin
    if (fill_en) tb_mem[fill_addr] <= fill_data;
    else if (mem_we) tb_mem[mem_wr_addr] <= mem_wr_din;
  end
  assign mem_rd_dout = tb_mem[mem_rd_addr];

  // Reference model state
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               prev_win;
  bit               exp_rv [2];
  logic [WIDTH-1:0] exp_rd [2];
  logic [WIDTH-1:0] hold   [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_ready0", 64'(req0_ready), 64'(0));
    check("rst_ready1", 64'(req1_ready), 64'(0));
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'(0));
    check("rst_rsp1_valid", 64'(rsp1_valid), 64'(0));
    check("rst_rsp0_rdata", 64'(rsp0_rdata), 64'(0));
    check("rst_rsp1_rdata", 64'(rsp1_rdata), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_busy", 64'(busy), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    prev_win = 1;
    for (int p = 0; p < 2; p++) begin
      exp_rv[p] = 1'b0;
      hold[p]   = '0;
    end
  endtask

  task automatic check_clear(input int n);
    for (int i = 0; i < n; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_we    = 1'($urandom_range(0, 1));
      req1_we    = 1'($urandom_range(0, 1));
      req0_addr  = ADDR_W'($urandom);
      req1_addr  = ADDR_W'($urandom);
      #1;
      check("clr_busy", 64'(busy), 64'(1));
      check("clr_mem_we", 64'(mem_we), 64'(1));
      check("clr_wr_addr", 64'(mem_wr_addr), 64'(i));
      check("clr_wr_din", 64'(mem_wr_din), 64'(0));
      check("clr_ready0", 64'(req0_ready), 64'(0));
      check("clr_ready1", 64'(req1_ready), 64'(0));
      check("clr_rsp0_valid", 64'(rsp0_valid), 64'(0));
      @(negedge clk);
    end
  endtask

  task automatic post_clear();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("post_clr_busy", 64'(busy), 64'(0));
    check("post_clr_mem_we", 64'(mem_we), 64'(0));
    check("post_clr_rsp0_valid", 64'(rsp0_valid), 64'(0));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clk);
  endtask

  // One serving cycle: drive at negedge, compare, advance model to the next edge
  task automatic step(input bit v0, input bit we0, input logic [ADDR_W-1:0] a0,
                      input logic [WIDTH-1:0] d0, input bit v1, input bit we1,
                      input logic [ADDR_W-1:0] a1, input logic [WIDTH-1:0] d1);
    bit                ww [2];
    logic [ADDR_W-1:0] aa [2];
    logic [WIDTH-1:0]  dd [2];
    int                winner;
    bit                e_we;
    logic [ADDR_W-1:0] e_wa, e_ra;
    logic [WIDTH-1:0]  e_wd;
    ww = '{we0, we1};
    aa = '{a0, a1};
    dd = '{d0, d1};
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
    check("rsp0_valid", 64'(rsp0_valid), 64'(exp_rv[0]));
    check("rsp0_rdata", 64'(rsp0_rdata), 64'(exp_rv[0] ? exp_rd[0] : hold[0]));
    check("rsp1_valid", 64'(rsp1_valid), 64'(exp_rv[1]));
    check("rsp1_rdata", 64'(rsp1_rdata), 64'(exp_rv[1] ? exp_rd[1] : hold[1]));
    for (int p = 0; p < 2; p++) if (exp_rv[p]) hold[p] = exp_rd[p];

    if (v0 && v1)  winner = 1 - prev_win;
    else if (v0)   winner = 0;
    else if (v1)   winner = 1;
    else           winner = -1;

    e_we = 1'b0; e_wa = '0; e_wd = '0; e_ra = '0;
    if (winner >= 0) begin
      if (ww[winner]) begin
        e_we = 1'b1; e_wa = aa[winner]; e_wd = dd[winner];
      end else begin
        e_ra = aa[winner];
      end
    end
    check("ready0", 64'(req0_ready), 64'(winner == 0));
    check("ready1", 64'(req1_ready), 64'(winner == 1));
    check("busy", 64'(busy), 64'(0));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_wr_addr", 64'(mem_wr_addr), 64'(e_wa));
    check("mem_wr_din", 64'(mem_wr_din), 64'(e_wd));
    check("mem_rd_addr", 64'(mem_rd_addr), 64'(e_ra));

    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (winner >= 0) begin
      if (ww[winner]) begin
        ref_mem[aa[winner]] = dd[winner];
      end else begin
        exp_rv[winner] = 1'b1;
        exp_rd[winner] = ref_mem[aa[winner]];
      end
      prev_win = winner;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

    fill_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fill_addr = ADDR_W'(i);
      fill_data = $urandom | 32'h1;
      @(negedge clk);
    end
    fill_en = 1'b0;

    apply_reset();
    check_clear(DEPTH);
    post_clear();

    // write from req1, read back on req0
    step(1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF);
    step(1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    idle();
    idle();

    // tie-breaking alternation with both requesters reading
    step(1'b1, 1'b1, 7'd1, 32'h11111111, 1'b0, 1'b0, 7'd0, 32'h0);
    step(1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b1, 7'd2, 32'h22222222);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 7'd1, 32'h0, 1'b1, 1'b0, 7'd2, 32'h0);
    idle();

    // back-to-back reads on req0
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, ADDR_W'(k), 32'hA0A0_0000 + 32'(k), 1'b0, 1'b0, 7'd0, 32'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, ADDR_W'(k), 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    idle();
    idle();

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
           $urandom, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           ADDR_W'($urandom_range(0, 15)), $urandom);
    idle();

    // read granted, then reset before its response is captured
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'd3;
    req1_valid = 1'b0;
    #1;
    check("inflight_ready0", 64'(req0_ready), 64'(1));
    apply_reset();
    check_clear(DEPTH);
    post_clear();

    // reset mid-clear restarts at address 0
    apply_reset();
    check_clear(60);
    apply_reset();
    check_clear(DEPTH);
    post_clear();

    step(1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
    step(1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, 7'd127, 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
